// File: rtl/fetch_prefetch_ctrl_if.sv
// Interface bundling the instruction-memory port, the redirect request and the
// IF/ID valid/ready handshake of the fetch prefetch controller.
//   master : the fetch controller (drives imem_en/imem_addr and the if_* head)
//   slave  : the environment (memory, redirect source and IF/ID consumer)
interface fetch_prefetch_ctrl_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_fault,
        input  if_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_fault,
        output if_ready
    );
endinterface

// File: rtl/fetch_prefetch_ctrl.sv
// Instruction-fetch controller. Owns the fetch PC, reads the combinational
// instruction memory one word per cycle and buffers the words in a small
// prefetch FIFO whose head is offered to IF/ID over a valid/ready handshake.
// Redirects flush the FIFO and restart fetch; misaligned or out-of-range
// fetches push a NOP fault entry and halt fetch until the next redirect.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_prefetch_ctrl_if.master (imem_*, redirect_*, if_*)
//
// state | meaning
// BOOT  | one cycle after reset release, no fetch, redirects ignored
// FETCH | memory enabled, one push per cycle whenever there is room
// HALT  | a fault entry was pushed; fetch stopped until a redirect
module fetch_prefetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_prefetch_ctrl_if.master bus
);
    localparam int              PTR_W      = $clog2(DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [29:0]     WORD_LIMIT = 30'(IMEM_WORDS);
    localparam logic [31:0]     NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        fetch_pc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pc_q    [DEPTH];
    logic [31:0]        instr_q [DEPTH];
    logic               fault_q [DEPTH];

    logic redirect;
    logic pop;
    logic push;
    logic fetch_fault;

    assign redirect    = bus.redirect_valid && (state != BOOT);
    assign pop         = (count != '0) && bus.if_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still streams.
    assign push        = (state == FETCH) && ((count < FULL_CNT) || pop);
    assign fetch_fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:2] >= WORD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_nxt = FETCH;
                end else if (push && fetch_fault) begin
                    state_nxt = HALT;
                end
            end
            HALT:  begin
                if (redirect) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        bus.imem_en   = (state == FETCH);
        bus.imem_addr = fetch_pc;
        bus.if_valid  = (count != '0);
        bus.if_instr  = instr_q[rd_ptr];
        bus.if_pc     = pc_q[rd_ptr];
        bus.if_fault  = fault_q[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= bus.redirect_pc;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Redirect wins over any same-cycle push/pop: those are simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                fault_q[i] <= 1'b0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]    <= fetch_pc;
                instr_q[wr_ptr] <= fetch_fault ? NOP : bus.imem_rdata;
                fault_q[wr_ptr] <= fetch_fault;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Bench for fetch_prefetch_ctrl: directed scenarios followed by random
// ready/redirect traffic, all checked against a queue-based model of the
// fetch stream kept in the bench.
module tb_fetch_prefetch_ctrl;
    localparam int          DEPTH      = 2;
    localparam int          IMEM_WORDS = 1024;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [0:IMEM_WORDS-1];

    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_mode;   // 0 boot, 1 fetching, 2 halted

    fetch_prefetch_ctrl_if bus();

    fetch_prefetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (DEPTH),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory returns 0 while disabled.
    always_comb begin
        bus.imem_rdata = 32'h0;
        if (bus.imem_en && (bus.imem_addr[31:2] < 30'(IMEM_WORDS)))
            bus.imem_rdata = mem[bus.imem_addr[11:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = 32'h0;
        m_mode = 0;
    endtask

    task automatic check_model();
        chk("valid", 32'(bus.if_valid), 32'(q.size() != 0));
        chk("imem_en", 32'(bus.imem_en), 32'(m_mode == 1));
        chk("imem_addr", bus.imem_addr, m_pc);
        if (q.size() != 0) begin
            chk("head_pc", bus.if_pc, q[0].pc);
            chk("head_instr", bus.if_instr, q[0].instr);
            chk("head_fault", 32'(bus.if_fault), 32'(q[0].fault));
        end
    endtask

    task automatic model_update(input logic rdy, input logic rv, input logic [31:0] rpc);
        bit   popd;
        bit   room;
        ent_t e;
        popd = (q.size() != 0) && rdy;
        if (m_mode != 0 && rv) begin
            q.delete();
            m_pc   = rpc;
            m_mode = 1;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
            return;
        end
        room = (q.size() < DEPTH) || popd;
        if (popd) void'(q.pop_front());
        if (m_mode == 1 && room) begin
            e.pc    = m_pc;
            e.fault = (m_pc[1:0] != 2'b00) || ((m_pc >> 2) >= 32'(IMEM_WORDS));
            e.instr = e.fault ? NOP : mem[m_pc[11:2]];
            q.push_back(e);
            m_pc = m_pc + 32'd4;
            if (e.fault) m_mode = 2;
        end
    endtask

    // Drive one cycle's inputs, check the current outputs, advance model and DUT.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.if_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        check_model();
        model_update(rdy, rv, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] rpc;
        int          r;

        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0A0_0000 + 32'(i);
        model_reset();

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_instr", bus.if_instr, 32'h0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_fault", 32'(bus.if_fault), 32'h0);
        chk("rst_en", 32'(bus.imem_en), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        rst = 1'b0;

        // 1: boot then stream 0,4,8,C
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_pc", bus.if_pc, 32'(4 * i));
            chk("t1_instr", bus.if_instr, 32'hA0A0_0000 + 32'(i));
            step(1'b1, 1'b0, 32'h0);
        end

        // 2: back-pressure fills FIFO, pc stalls at 8
        sync_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        chk("t2_addr", bus.imem_addr, 32'h8);
        chk("t2_head", bus.if_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_valid", 32'(bus.if_valid), 32'h1);
            chk("t2_pc", bus.if_pc, 32'(4 * i));
            step(1'b1, 1'b0, 32'h0);
        end

        // 3: redirect while full
        step(1'b1, 1'b1, 32'h40);
        chk("t3_valid", 32'(bus.if_valid), 32'h0);
        chk("t3_addr", bus.imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'h0);
        chk("t3_pc", bus.if_pc, 32'h40);
        chk("t3_instr", bus.if_instr, mem[16]);

        // 4: out-of-range fetch faults and halts; redirect resumes
        step(1'b0, 1'b1, 32'h1000);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_fault", 32'(bus.if_fault), 32'h1);
        chk("t4_instr", bus.if_instr, NOP);
        chk("t4_en", 32'(bus.imem_en), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h8);
        chk("t4_addr", bus.imem_addr, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_resume", bus.if_pc, 32'h8);

        // 5: misaligned redirect
        step(1'b0, 1'b1, 32'h6);
        step(1'b0, 1'b0, 32'h0);
        chk("t5_pc", bus.if_pc, 32'h6);
        chk("t5_fault", 32'(bus.if_fault), 32'h1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3, 4, 5: rpc = {20'h0, 10'($urandom_range(0, IMEM_WORDS - 1)), 2'b00};
                6, 7:             rpc = 32'($urandom_range(IMEM_WORDS - 4, IMEM_WORDS + 3)) << 2;
                8:                rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
                default:          rpc = $urandom;
            endcase
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, rpc);
        end

        // 6: async reset mid-stream, redirect during BOOT ignored
        step(1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(bus.if_valid), 32'h0);
        chk("t6_en", 32'(bus.imem_en), 32'h0);
        chk("t6_addr", bus.imem_addr, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        step(1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b0, 32'h0);
        chk("t6_restart", bus.if_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
